m2_decode: RTL and testbench

//  Manchester-II receive stage, directly downstream of the M2 transmit encoder: recovers 40-half-bit words from the

---
 rtl/m2_decode.sv | 161 ++++++++++++++++
 tb/tb_m2_decode.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/m2_decode.sv
// Manchester-II receive stage: sync detection, half-bit sampling, pair/parity decode,
// and FIFO write of good words as {is_cmd, data[15:0]}.
module m2_decode #(
    parameter int OSR     = 8,
    parameter int GAP_MIN = 20
) (
    input  logic        clock_334p128k,
    input  logic        rstn,
    input  logic        m2_bzi,
    input  logic        m2_boi,
    input  logic        full,
    output logic        wr_en,
    output logic [16:0] wr_data,
    output logic        word_done,
    output logic        perr,
    output logic        merr,
    output logic        sync_err,
    output logic        overflow
);

    localparam int SW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [SW-1:0] SUB_MID  = SW'(OSR / 2);
    localparam logic [SW-1:0] SUB_LAST = SW'(OSR - 1);
    localparam logic [7:0]    GAP_L    = 8'(GAP_MIN);

    typedef enum logic [1:0] {IDLE, SYNC, RECV, DONE} state_t;

    state_t         state_reg, state_next;
    logic           bzi_meta_reg, bzi_s_reg, boi_meta_reg, boi_s_reg;
    logic           level_prev_reg;
    logic [7:0]     low_run_reg;
    logic [SW-1:0]  sub_reg;
    logic [5:0]     hb_reg;
    // Only the last 34 half-bits are ever decoded; sync half-bits are checked on the fly.
    logic [33:0]    sr_reg;
    logic           line_err_reg;
    logic           is_cmd_reg;

    logic           level, line_bad, rise, sample, cmd_sync;
    logic [5:0]     last_hb;
    logic [15:0]    data_c, pair_bad;
    logic           merr_c, parity_ok;
    logic           wr_en_next, word_done_next, perr_next, merr_next, sync_err_next, ovf_set;

    assign level    = bzi_s_reg;
    assign line_bad = (bzi_s_reg == boi_s_reg);
    assign rise     = level && !level_prev_reg;
    assign sample   = ((state_reg == SYNC) || (state_reg == RECV)) && (sub_reg == SUB_MID);
    assign cmd_sync = (sr_reg[1:0] == 2'b00) && !level;
    assign last_hb  = is_cmd_reg ? 6'd39 : 6'd36;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pair
            assign data_c[gi]   = sr_reg[2*gi+3];
            assign pair_bad[gi] = (sr_reg[2*gi+3] == sr_reg[2*gi+2]);
        end
    endgenerate

    assign merr_c    = (|pair_bad) || (sr_reg[1] == sr_reg[0]) || line_err_reg;
    assign parity_ok = ((^data_c) ^ sr_reg[1]) == 1'b1;

    always_comb begin
        state_next     = state_reg;
        wr_en_next     = 1'b0;
        word_done_next = 1'b0;
        perr_next      = 1'b0;
        merr_next      = 1'b0;
        sync_err_next  = 1'b0;
        ovf_set        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rise && (low_run_reg >= GAP_L)) state_next = SYNC;
            end
            SYNC: begin
                if (sample) begin
                    if ((hb_reg <= 6'd2) && !level) begin
                        sync_err_next = 1'b1;
                        state_next    = IDLE;
                    end else if (hb_reg == 6'd5) begin
                        state_next = RECV;
                    end
                end
            end
            RECV: begin
                if (sample && (hb_reg == last_hb)) state_next = DONE;
            end
            DONE: begin
                state_next     = IDLE;
                word_done_next = 1'b1;
                merr_next      = merr_c;
                perr_next      = !merr_c && !parity_ok;
                if (!merr_c && parity_ok) begin
                    if (full) ovf_set = 1'b1;
                    else      wr_en_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_334p128k or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            bzi_meta_reg   <= 1'b0;
            bzi_s_reg      <= 1'b0;
            boi_meta_reg   <= 1'b0;
            boi_s_reg      <= 1'b0;
            level_prev_reg <= 1'b0;
            low_run_reg    <= 8'd0;
            sub_reg        <= '0;
            hb_reg         <= 6'd0;
            sr_reg         <= '0;
            line_err_reg   <= 1'b0;
            is_cmd_reg     <= 1'b0;
            wr_en          <= 1'b0;
            wr_data        <= 17'd0;
            word_done      <= 1'b0;
            perr           <= 1'b0;
            merr           <= 1'b0;
            sync_err       <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            bzi_meta_reg   <= m2_bzi;
            bzi_s_reg      <= bzi_meta_reg;
            boi_meta_reg   <= m2_boi;
            boi_s_reg      <= boi_meta_reg;
            level_prev_reg <= level;

            if (level || line_bad)       low_run_reg <= 8'd0;
            else if (low_run_reg != 8'hFF) low_run_reg <= low_run_reg + 8'd1;

            state_reg <= state_next;
            wr_en     <= wr_en_next;
            word_done <= word_done_next;
            perr      <= perr_next;
            merr      <= merr_next;
            sync_err  <= sync_err_next;
            if (wr_en_next) wr_data  <= {is_cmd_reg, data_c};
            if (ovf_set)    overflow <= 1'b1;

            if ((state_reg == IDLE) && (state_next == SYNC)) begin
                sub_reg      <= '0;
                hb_reg       <= 6'd0;
                line_err_reg <= 1'b0;
            end else if ((state_reg == SYNC) || (state_reg == RECV)) begin
                if (sub_reg == SUB_LAST) begin
                    sub_reg <= '0;
                    hb_reg  <= hb_reg + 6'd1;
                end else begin
                    sub_reg <= sub_reg + 1'b1;
                end
                if (sample) begin
                    sr_reg <= {sr_reg[32:0], level};
                    if (line_bad) line_err_reg <= 1'b1;
                    if ((state_reg == SYNC) && (hb_reg == 6'd5)) is_cmd_reg <= cmd_sync;
                end
            end
        end
    end

endmodule

// File: tb/tb_m2_decode.sv
// Scoreboard bench for m2_decode: directed words are encoded on the line pair,
// expected events are queued and a negedge monitor compares each DUT event.
module tb_m2_decode;

    localparam int OSR = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        bzi = 1'b0;
    logic        boi = 1'b1;
    logic        full = 1'b0;
    logic        wr_en, word_done, perr, merr, sync_err, overflow;
    logic [16:0] wr_data;

    always #5 clk = ~clk;

    m2_decode #(.OSR(OSR), .GAP_MIN(20)) dut (
        .clock_334p128k(clk),
        .rstn(rstn),
        .m2_bzi(bzi),
        .m2_boi(boi),
        .full(full),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .word_done(word_done),
        .perr(perr),
        .merr(merr),
        .sync_err(sync_err),
        .overflow(overflow)
    );

    typedef struct packed {
        logic        wr;
        logic        done;
        logic        pe;
        logic        me;
        logic        se;
        logic [16:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [39:0] w;
    int          wlen;

    task automatic push(input logic wr, input logic done, input logic pe, input logic me,
                        input logic se, input logic [16:0] data);
        ev_t e;
        e = '{wr: wr, done: done, pe: pe, me: me, se: se, data: data};
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic idle(input int n_hb);
        repeat (n_hb * OSR) begin
            @(negedge clk);
            bzi = 1'b0;
            boi = 1'b1;
        end
    endtask

    task automatic build(input logic cmd, input logic [15:0] d);
        int   p;
        logic par;
        w = '0;
        w[0] = 1'b1; w[1] = 1'b1; w[2] = 1'b1;
        p = cmd ? 6 : 3;
        for (int i = 15; i >= 0; i--) begin
            w[p]   = d[i];
            w[p+1] = ~d[i];
            p += 2;
        end
        par    = ~(^d);
        w[p]   = par;
        w[p+1] = ~par;
        wlen   = p + 2;
    endtask

    // Send the built word; glitch_hb forces bzi==boi on the sampled clock of that half-bit.
    task automatic send(input int glitch_hb, input int stop_hb);
        for (int k = 0; k < wlen && k < stop_hb; k++) begin
            for (int j = 0; j < OSR; j++) begin
                @(negedge clk);
                bzi = w[k];
                boi = (k == glitch_hb && j == 5) ? w[k] : ~w[k];
            end
        end
    endtask

    always @(negedge clk) begin
        ev_t obs;
        ev_t e;
        if (rstn && (wr_en || word_done || perr || merr || sync_err)) begin
            obs = '{wr: wr_en, done: word_done, pe: perr, me: merr, se: sync_err,
                    data: (wr_en ? wr_data : 17'h0)};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual=%h required=none", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    failures++;
                    $display("FAIL event actual=%h required=%h", obs, e);
                end else begin
                    $display("ok   event wr=%b done=%b perr=%b merr=%b sync_err=%b data=%h",
                             obs.wr, obs.done, obs.pe, obs.me, obs.se, obs.data);
                end
            end
        end
    end

    initial begin
        idle(3);
        chk("reset_flags", {26'd0, wr_en, word_done, perr, merr, sync_err, overflow}, 32'd0);
        chk("reset_wr_data", {15'd0, wr_data}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // 1: command after long idle
        idle(10);
        build(1'b1, 16'hA55A); push(1, 1, 0, 0, 0, 17'h1A55A); send(-1, 40); idle(3);

        // 2: command then two data words
        build(1'b1, 16'h0000); push(1, 1, 0, 0, 0, 17'h10000); send(-1, 40); idle(3);
        build(1'b0, 16'h1234); push(1, 1, 0, 0, 0, 17'h01234); send(-1, 40); idle(3);
        build(1'b0, 16'h8000); push(1, 1, 0, 0, 0, 17'h08000); send(-1, 40); idle(3);

        // 3: data word whose first three half-bits after sync are 010
        build(1'b0, 16'h0001); push(1, 1, 0, 0, 0, 17'h00001); send(-1, 40); idle(3);

        // 4: inverted parity pair, then a forced 11 pair on bit 7
        build(1'b1, 16'h00FF); w[38] = ~w[38]; w[39] = ~w[39];
        push(0, 1, 1, 0, 0, 17'h0); send(-1, 40); idle(3);
        build(1'b0, 16'h1234); w[19] = 1'b1; w[20] = 1'b1;
        push(0, 1, 0, 1, 0, 17'h0); send(-1, 40); idle(3);

        // 5: FIFO full drops a good word; overflow is sticky
        full = 1'b1;
        build(1'b1, 16'h1111); push(0, 1, 0, 0, 0, 17'h0); send(-1, 40); idle(3);
        full = 1'b0;
        chk("overflow_set", {31'd0, overflow}, 32'd1);
        build(1'b1, 16'h2222); push(1, 1, 0, 0, 0, 17'h12222); send(-1, 40); idle(3);
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);
        push(0, 0, 0, 0, 1, 17'h0);
        repeat (OSR) begin
            @(negedge clk);
            bzi = 1'b1;
            boi = 1'b0;
        end
        idle(6);

        // 6: reset mid-word, then clean word, then a one-sample line fault
        build(1'b1, 16'h7777); send(-1, 20);
        @(negedge clk);
        rstn = 1'b0; bzi = 1'b0; boi = 1'b1;
        repeat (2) @(negedge clk);
        chk("overflow_after_reset", {31'd0, overflow}, 32'd0);
        rstn = 1'b1;
        idle(10);
        build(1'b1, 16'h5A5A); push(1, 1, 0, 0, 0, 17'h15A5A); send(-1, 40); idle(3);
        build(1'b1, 16'h3C3C); push(0, 1, 0, 1, 0, 17'h0); send(20, 40); idle(4);

        chk("pending_events", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
